fetch_sequencer: RTL and testbench

Instruction-fetch controller sitting between the PC/branch logic and the instruction memory. Owns the fetch PC and issues word reads over a req/ack handshake. Buffers returned instructions with their PCs in a DEPTH-entry prefetch queue for the decode stage. Handles branch redirects (flush, discard of in-flight data) and out-of-range or misaligned fetch faults.

---
 rtl/fetch_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the fetch PC, issues one word read at a
// time over a req/ack handshake, and buffers {pc, instr} pairs in a small
// first-word-fall-through prefetch queue for decode. Redirects flush the
// queue and drop any in-flight word; illegal fetch PCs raise a fault once the
// queue has drained.
module fetch_sequencer #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter logic [31:0] MEM_BASE  = 32'h0040_0000,
    parameter logic [31:0] MEM_LIMIT = 32'h0040_4000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        fault,
    output logic [31:0] fault_pc
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_DISCARD = 2'd1;
    localparam logic [1:0] ST_FAULT   = 2'd2;

    // Fetch address is legal when word aligned and inside the memory window.
    function automatic logic is_legal(input logic [31:0] addr);
        return (addr >= MEM_BASE) && (addr <= MEM_LIMIT) && (addr[1:0] == 2'b00);
    endfunction

    logic [1:0]       r_state;
    logic [31:0]      r_fetch_pc;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic             r_mem_req;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_fault_pc;

    logic [1:0]       w_state_next;
    logic [31:0]      w_fetch_pc_next;
    logic [CNT_W-1:0] w_count_next;
    logic [PTR_W-1:0] w_rd_ptr_next;
    logic [PTR_W-1:0] w_wr_ptr_next;
    logic             w_mem_req_next;
    logic [31:0]      w_mem_addr_next;
    logic [31:0]      w_fault_pc_next;

    logic             w_legal;
    logic             w_push;
    logic             w_pop;
    logic [31:0]      w_pc_inc;
    logic [31:0]      w_pc_after;
    logic [CNT_W-1:0] w_count_upd;

    logic [31:0] w_entry_pc    [DEPTH];
    logic [31:0] w_entry_instr [DEPTH];

    assign w_legal    = is_legal(r_fetch_pc);
    // Only words fetched in RUN are kept; a redirect in the same cycle wins.
    assign w_push     = r_mem_req && mem_ack && (r_state == ST_RUN) && !redirect_valid;
    assign w_pop      = (r_count != '0) && out_ready && !redirect_valid;
    assign w_pc_inc   = r_fetch_pc + 32'd4;
    assign w_pc_after = w_push ? w_pc_inc : r_fetch_pc;
    assign w_count_upd = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // Next-state logic for the control FSM, fetch PC, request and queue pointers.
    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        w_count_next    = r_count;
        w_rd_ptr_next   = r_rd_ptr;
        w_wr_ptr_next   = r_wr_ptr;
        w_mem_req_next  = r_mem_req;
        w_mem_addr_next = r_mem_addr;
        w_fault_pc_next = r_fault_pc;

        if (redirect_valid) begin
            w_count_next    = '0;
            w_rd_ptr_next   = '0;
            w_wr_ptr_next   = '0;
            w_fetch_pc_next = redirect_pc;
            w_fault_pc_next = '0;
            if (r_mem_req && !mem_ack) begin
                // Request still in flight: keep it up with its old address
                // and throw the returning word away.
                w_state_next = ST_DISCARD;
            end else begin
                w_state_next   = ST_RUN;
                w_mem_req_next = 1'b0;
            end
        end else begin
            w_count_next = w_count_upd;
            if (w_push) begin
                w_wr_ptr_next   = r_wr_ptr + PTR_W'(1);
                w_fetch_pc_next = w_pc_inc;
            end
            if (w_pop) begin
                w_rd_ptr_next = r_rd_ptr + PTR_W'(1);
            end

            case (r_state)
                ST_RUN: begin
                    if (r_mem_req && !mem_ack) begin
                        // Request held until the memory answers.
                        w_mem_req_next = 1'b1;
                    end else if (!w_legal) begin
                        w_state_next    = ST_FAULT;
                        w_fault_pc_next = r_fetch_pc;
                        w_mem_req_next  = 1'b0;
                    end else begin
                        w_mem_req_next  = is_legal(w_pc_after) && (w_count_upd < FULL_COUNT);
                        w_mem_addr_next = w_pc_after;
                    end
                end
                ST_DISCARD: begin
                    if (mem_ack) begin
                        w_state_next   = ST_RUN;
                        w_mem_req_next = 1'b0;
                    end
                end
                ST_FAULT: begin
                    w_mem_req_next = 1'b0;
                end
                default: begin
                    w_state_next   = ST_RUN;
                    w_mem_req_next = 1'b0;
                end
            endcase
        end
    end

    // Control and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_fetch_pc <= RESET_PC;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_fault_pc <= '0;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_count    <= w_count_next;
            r_rd_ptr   <= w_rd_ptr_next;
            r_wr_ptr   <= w_wr_ptr_next;
            r_mem_req  <= w_mem_req_next;
            r_mem_addr <= w_mem_addr_next;
            r_fault_pc <= w_fault_pc_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [31:0] r_pc;
            logic [31:0] r_instr;
            logic        w_load;

            assign w_load = w_push && (r_wr_ptr == PTR_W'(gi));

            // Capture the returned word into this slot when it is the tail.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pc    <= '0;
                    r_instr <= '0;
                end else if (w_load) begin
                    r_pc    <= r_fetch_pc;
                    r_instr <= mem_rdata;
                end
            end

            assign w_entry_pc[gi]    = r_pc;
            assign w_entry_instr[gi] = r_instr;
        end
    endgenerate

    assign out_valid = (r_count != '0);
    assign out_pc    = w_entry_pc[r_rd_ptr];
    assign out_instr = w_entry_instr[r_rd_ptr];
    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign fault     = (r_state == ST_FAULT) && (r_count == '0);
    assign fault_pc  = r_fault_pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by a random phase,
// all checked against a transaction-level model (a queue of fetched PCs, the
// expected fetch PC and a discard flag).
module tb_fetch_sequencer;

    localparam int          DEPTH     = 4;
    localparam logic [31:0] RESET_PC  = 32'h0040_0000;
    localparam logic [31:0] MEM_BASE  = 32'h0040_0000;
    localparam logic [31:0] MEM_LIMIT = 32'h0040_4000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_ready = 1'b0;
    logic        mem_ack = 1'b0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        fault;
    logic [31:0] fault_pc;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit addr_ok(input logic [31:0] a);
        return (a >= MEM_BASE) && (a <= MEM_LIMIT) && (a[1:0] == 2'b00);
    endfunction

    assign mem_rdata = mem_word(mem_addr);

    fetch_sequencer #(
        .DEPTH(DEPTH), .RESET_PC(RESET_PC), .MEM_BASE(MEM_BASE), .MEM_LIMIT(MEM_LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .fault(fault), .fault_pc(fault_pc)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [31:0] q_pc[$];
    logic [31:0] m_pc;
    bit          m_disc;
    logic [31:0] m_disc_addr;
    bit          m_hold;
    int          m_ill;
    int          m_idle;
    int          n_push = 0;
    int          n_pop = 0;
    logic [31:0] last_pop_pc = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_pc.delete();
        m_pc   = RESET_PC;
        m_disc = 1'b0;
        m_hold = 1'b0;
        m_ill  = 0;
        m_idle = 0;
    endtask

    task automatic reset_checks();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_instr", out_instr, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_fault_pc", fault_pc, 0);
    endtask

    // Called between edges with inputs already driven: check outputs against
    // the model, advance the model across the coming edge, then move to #1
    // after that edge.
    task automatic tick();
        bit ack;
        check("out_valid", 32'(out_valid), 32'(q_pc.size() != 0));
        if (q_pc.size() != 0) begin
            check("out_pc", out_pc, q_pc[0]);
            check("out_instr", out_instr, mem_word(q_pc[0]));
        end
        if (m_hold) check("req_hold", 32'(mem_req), 1);
        if (m_disc) begin
            check("disc_addr", mem_addr, m_disc_addr);
        end else begin
            check("req_gate", 32'(mem_req),
                  32'(mem_req && addr_ok(m_pc) && (q_pc.size() < DEPTH)));
            if (mem_req) check("req_addr", mem_addr, m_pc);
            if (addr_ok(m_pc) && (q_pc.size() < DEPTH) && !mem_req) m_idle++;
            else m_idle = 0;
            if (m_idle >= 2) check("req_live", 32'(mem_req), 1);
        end
        check("fault", 32'(fault), 32'((m_ill >= 2) && (q_pc.size() == 0)));
        if (fault) check("fault_pc", fault_pc, m_pc);

        ack = mem_req && mem_ack;
        if (redirect_valid) begin
            if (mem_req && !mem_ack && !m_disc) m_disc_addr = m_pc;
            m_disc = mem_req && !mem_ack;
            q_pc.delete();
            m_pc   = redirect_pc;
            m_ill  = 0;
            m_idle = 0;
        end else begin
            if ((q_pc.size() != 0) && out_ready) begin
                last_pop_pc = q_pc.pop_front();
                n_pop++;
            end
            if (ack) begin
                if (m_disc) begin
                    m_disc = 1'b0;
                end else begin
                    q_pc.push_back(m_pc);
                    m_pc = m_pc + 32'd4;
                    n_push++;
                end
            end
        end
        m_hold = mem_req && !mem_ack;
        if (!m_disc && !addr_ok(m_pc)) m_ill++;
        else m_ill = 0;

        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        redirect_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        reset_checks();
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
        redirect_pc    = $urandom;
    endtask

    initial begin
        int first_req;
        int first_valid;
        int p0;
        int q0;

        #1;
        // Streaming with ack tied high and decode always ready
        do_reset();
        mem_ack = 1'b1;
        out_ready = 1'b1;
        first_req = -1;
        first_valid = -1;
        p0 = n_push;
        q0 = n_pop;
        for (int i = 0; i < 20; i++) begin
            if (mem_req && first_req < 0) begin
                first_req = i;
                check("t1_first_addr", mem_addr, RESET_PC);
            end
            if (out_valid && first_valid < 0) first_valid = i;
            tick();
        end
        check("t1_latency", 32'(first_valid - first_req), 1);
        check("t1_pushes", 32'(n_push - p0), 19);
        check("t1_pops", 32'(n_pop - q0), 18);
        $display("t1 stream: pushes=%0d pops=%0d", n_push - p0, n_pop - q0);

        // Back-pressure fills the queue, then drains
        do_reset();
        out_ready = 1'b0;
        p0 = n_push;
        for (int i = 0; i < 10; i++) tick();
        check("t2_pushes", 32'(n_push - p0), 4);
        check("t2_req_full", 32'(mem_req), 0);
        check("t2_valid_full", 32'(out_valid), 1);
        out_ready = 1'b1;
        check("t2_req_before_pop", 32'(mem_req), 0);
        tick();
        check("t2_first_pop", last_pop_pc, RESET_PC);
        check("t2_req_resume", 32'(mem_req), 1);
        for (int i = 0; i < 12; i++) tick();
        $display("t2 backpressure: last popped pc=%h", last_pop_pc);

        // Redirect while a slow request is outstanding
        do_reset();
        mem_ack = 1'b0;
        for (int i = 0; i < 10 && !mem_req; i++) tick();
        check("t3_req_seen", 32'(mem_req), 1);
        check("t3_addr", mem_addr, RESET_PC);
        do_redirect(32'h0040_0100);
        tick();
        check("t3_hold_req", 32'(mem_req), 1);
        check("t3_hold_addr", mem_addr, RESET_PC);
        mem_ack = 1'b1;
        tick();
        check("t3_empty", 32'(out_valid), 0);
        for (int i = 0; i < 10 && !mem_req; i++) tick();
        check("t3_req_new", 32'(mem_req), 1);
        check("t3_addr_new", mem_addr, 32'h0040_0100);
        tick();
        tick();
        check("t3_first_pop", last_pop_pc, 32'h0040_0100);
        $display("t3 discard: new fetch addr=%h", 32'h0040_0100);

        // Redirect in the same cycle as an ack and a pop, two entries queued
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 10 && q_pc.size() != 2; i++) tick();
        check("t4_valid", 32'(out_valid), 1);
        check("t4_req", 32'(mem_req), 1);
        out_ready = 1'b1;
        do_redirect(32'h0040_0200);
        check("t4_flushed", 32'(out_valid), 0);
        for (int i = 0; i < 10 && !mem_req; i++) tick();
        check("t4_addr", mem_addr, 32'h0040_0200);
        tick();
        tick();
        check("t4_first_pop", last_pop_pc, 32'h0040_0200);
        $display("t4 redirect+ack+pop: first pop=%h", last_pop_pc);

        // Run off the top of the memory window
        do_redirect(32'h0040_3FF0);
        for (int i = 0; i < 40 && !fault; i++) tick();
        check("t5_fault", 32'(fault), 1);
        check("t5_fault_pc", fault_pc, 32'h0040_4004);
        check("t5_last_pop", last_pop_pc, 32'h0040_4000);
        do_redirect(RESET_PC);
        check("t5_fault_clear", 32'(fault), 0);
        for (int i = 0; i < 10 && !mem_req; i++) tick();
        check("t5_resume_addr", mem_addr, RESET_PC);
        $display("t5 limit fault: fault_pc=%h", 32'h0040_4004);

        // Misaligned redirect, then reset mid-stream
        do_redirect(32'h0040_0002);
        for (int i = 0; i < 4; i++) tick();
        check("t6_fault", 32'(fault), 1);
        check("t6_fault_pc", fault_pc, 32'h0040_0002);
        check("t6_no_req", 32'(mem_req), 0);
        do_redirect(RESET_PC);
        for (int i = 0; i < 6; i++) tick();
        do_reset();
        for (int i = 0; i < 10 && !mem_req; i++) tick();
        check("t6_restart_addr", mem_addr, RESET_PC);
        $display("t6 misalign+reset: restart addr=%h", RESET_PC);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            mem_ack   = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 99) < 3) begin
                case ($urandom_range(0, 5))
                    0: do_redirect(32'h0040_0000 + ($urandom_range(0, 255) << 2));
                    1: do_redirect(32'h0040_3FF8);
                    2: do_redirect(32'h003F_FFFC);
                    3: do_redirect(32'h0040_4004);
                    4: do_redirect(32'h0040_0001);
                    default: do_redirect(32'h0040_4000);
                endcase
            end else begin
                tick();
            end
        end
        $display("random: pushes=%0d pops=%0d", n_push, n_pop);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
